// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the wait-state data memory responder:
// FSM encoding, default geometry and the request legality check.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DEF_ADDR_W      = 6;
  localparam int DEF_WAIT_CYCLES = 2;

  // A request is illegal if it is not word aligned or falls beyond the bank.
  function automatic logic addr_err(input logic [31:0] addr, input int addr_w);
    logic [31:0] hi_bits;
    hi_bits = addr >> (addr_w + 2);
    return (addr[1:0] != 2'b00) || (hi_bits != 32'd0);
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-organised storage with per-byte write enables and a combinational read.
// The array is intentionally left unreset.
module dmem_bank #(
  parameter int ADDR_W = 6
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [3:0]        be_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-port memory responder: accepts one request, waits WAIT_CYCLES cycles,
// performs the access in a single edge and holds the response until taken.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic        clkin,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("dmem_responder: WAIT_CYCLES must be within 0..15");
  end

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic        acc_we;
  logic [31:0] acc_addr;
  logic [3:0]  acc_be;
  logic [31:0] acc_wdata;
  logic        accept;
  logic        do_access;
  logic        acc_err;
  logic        bank_we;
  logic [31:0] bank_rdata;
  logic [31:0] rsp_rdata_d;
  logic        rsp_err_d;

  // With zero wait states the access happens on the accepting edge,
  // so the bank must see the live request rather than the latched copy.
  always_comb begin
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_be    = be_q;
    acc_wdata = wdata_q;
    if (state_q == IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_be    = req_be;
      acc_wdata = req_wdata;
    end
  end

  assign accept      = (state_q == IDLE) && req_valid;
  assign do_access   = (WAIT_CYCLES == 0) ? accept : ((state_q == WAIT) && (cnt_q == 4'd0));
  assign acc_err     = addr_err(acc_addr, ADDR_W);
  assign bank_we     = do_access && acc_we && !acc_err;
  assign rsp_rdata_d = (acc_err || acc_we) ? 32'd0 : bank_rdata;
  assign rsp_err_d   = acc_err;

  dmem_bank #(.ADDR_W(ADDR_W)) u_bank (
    .clk_i   (clkin),
    .we_i    (bank_we),
    .addr_i  (acc_addr[ADDR_W+1:2]),
    .be_i    (acc_be),
    .wdata_i (acc_wdata),
    .rdata_o (bank_rdata)
  );

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      be_q        <= 4'd0;
      wdata_q     <= 32'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            we_q        <= req_we;
            addr_q      <= req_addr;
            be_q        <= req_be;
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            if (do_access) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rsp_rdata_d;
              rsp_err_q   <= rsp_err_d;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (do_access) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          rsp_rdata_q <= 32'd0;
          rsp_err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states) checked
// against an array-based memory model with directed and random traffic.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic reset;
  logic [1:0]       req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [1:0][31:0] req_addr, req_wdata, rsp_rdata;
  logic [1:0][3:0]  req_be;

  int total = 0;
  int bad   = 0;

  logic [31:0] model [2][64];
  logic [31:0] exp_rdata [2];
  logic        exp_err [2];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(6), .WAIT_CYCLES(2)) u_dut0 (
    .clkin(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_be(req_be[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.ADDR_W(6), .WAIT_CYCLES(0)) u_dut1 (
    .clkin(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_be(req_be[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  function automatic int wait_of(input int sel);
    return (sel == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input int sel, input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready[sel]), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid[sel]), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata[sel], 32'd0);
    chk({tag, "_rsp_err"},   32'(rsp_err[sel]),   32'd0);
  endtask

  // Present a request, wait (bounded) for acceptance, then update the model.
  task automatic issue(input int sel, input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wdata,
                       input bit commit, output int waited);
    int idx;
    req_we[sel]    = we;
    req_addr[sel]  = addr;
    req_be[sel]    = be;
    req_wdata[sel] = wdata;
    req_valid[sel] = 1'b1;
    waited = 0;
    while (req_ready[sel] !== 1'b1 && waited < 40) begin
      step();
      waited++;
    end
    if (req_ready[sel] !== 1'b1) chk("accept_timeout", 32'(req_ready[sel]), 32'd1);
    step();
    req_valid[sel] = 1'b0;
    if ((addr % 4) != 0 || addr >= 32'd256) begin
      exp_err[sel]   = 1'b1;
      exp_rdata[sel] = 32'd0;
    end else begin
      idx = int'(addr / 4);
      exp_err[sel] = 1'b0;
      if (we) begin
        exp_rdata[sel] = 32'd0;
        if (commit) begin
          for (int i = 0; i < 4; i++)
            if (be[i]) model[sel][idx][8*i +: 8] = wdata[8*i +: 8];
        end
      end else begin
        exp_rdata[sel] = model[sel][idx];
      end
    end
  endtask

  // Wait for the response, check it, stall `hold` cycles, then retire it.
  task automatic collect(input int sel, input int hold, input string tag);
    int lat = 1;
    while (rsp_valid[sel] !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(wait_of(sel) + 1));
    chk({tag, "_rdata"},   rsp_rdata[sel], exp_rdata[sel]);
    chk({tag, "_err"},     32'(rsp_err[sel]), 32'(exp_err[sel]));
    for (int h = 0; h < hold; h++) begin
      step();
      chk({tag, "_stall_valid"}, 32'(rsp_valid[sel]), 32'd1);
      chk({tag, "_stall_rdata"}, rsp_rdata[sel], exp_rdata[sel]);
      chk({tag, "_stall_err"},   32'(rsp_err[sel]), 32'(exp_err[sel]));
      chk({tag, "_stall_ready"}, 32'(req_ready[sel]), 32'd0);
    end
    rsp_ready[sel] = 1'b1;
    step();
    rsp_ready[sel] = 1'b0;
    chk_idle(sel, {tag, "_retire"});
  endtask

  task automatic txn(input int sel, input logic we, input logic [31:0] addr,
                     input logic [3:0] be, input logic [31:0] wdata,
                     input int hold, input string tag);
    int waited;
    issue(sel, we, addr, be, wdata, 1'b1, waited);
    collect(sel, hold, tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before the test completed");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    int sel;
    logic we;
    logic [31:0] addr;

    reset     = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_be    = '0;
    req_wdata = '0;
    rsp_ready = '0;

    // Reset then idle
    repeat (3) step();
    for (int s = 0; s < 2; s++) chk_idle(s, "in_reset");
    reset = 1'b1;
    repeat (3) begin
      step();
      for (int s = 0; s < 2; s++) chk_idle(s, "post_reset");
    end

    // Give every word a known value so later loads are predictable
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 64; w++)
        txn(s, 1'b1, 32'(w * 4), 4'hF, $urandom, 0, "fill");

    // Store then load, byte lanes
    txn(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 0, "store_full");
    txn(0, 1'b0, 32'h10, 4'h0, 32'h0, 0, "load_full");
    chk("load_full_value", exp_rdata[0], 32'hDEADBEEF);
    txn(0, 1'b1, 32'h10, 4'b0101, 32'h11223344, 0, "store_lanes");
    txn(0, 1'b0, 32'h10, 4'h0, 32'h0, 0, "load_lanes");
    chk("load_lanes_value", rsp_rdata[0] | exp_rdata[0], 32'hDE22BE44);

    // Errors
    txn(0, 1'b0, 32'h12, 4'h0, 32'h0, 0, "err_misaligned");
    txn(0, 1'b1, 32'h100, 4'hF, 32'h55555555, 0, "err_range");
    txn(0, 1'b0, 32'h0, 4'h0, 32'h0, 0, "word0_after_err");
    txn(0, 1'b1, 32'h10, 4'h0, 32'hFFFFFFFF, 0, "store_be0");
    txn(0, 1'b0, 32'h10, 4'h0, 32'h0, 0, "load_after_be0");

    // Backpressure with a second request held pending
    issue(0, 1'b0, 32'h10, 4'h0, 32'h0, 1'b1, waited);
    req_we[0]    = 1'b0;
    req_addr[0]  = 32'h0;
    req_valid[0] = 1'b1;
    collect(0, 5, "bp_first");
    issue(0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, waited);
    chk("bp_second_accept_wait", 32'(waited), 32'd0);
    collect(0, 0, "bp_second");

    // Reset while a store is still waiting: it must not land
    issue(0, 1'b1, 32'h20, 4'hF, 32'hCAFEF00D, 1'b0, waited);
    step();
    reset = 1'b0;
    #1;
    chk_idle(0, "mid_wait_reset");
    step();
    reset = 1'b1;
    step();
    txn(0, 1'b0, 32'h20, 4'h0, 32'h0, 0, "load_after_reset");

    // Zero wait states
    txn(1, 1'b1, 32'h20, 4'hF, 32'hCAFEF00D, 0, "w0_store");
    txn(1, 1'b0, 32'h20, 4'h0, 32'h0, 2, "w0_load");
    txn(1, 1'b0, 32'h23, 4'h0, 32'h0, 0, "w0_err");

    // Random traffic on both instances
    for (int n = 0; n < 150; n++) begin
      sel = int'($urandom_range(0, 1));
      we  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       addr = $urandom;
        1:       addr = 32'($urandom_range(0, 63) * 4) | 32'($urandom_range(1, 3));
        2:       addr = 32'h100 + 32'($urandom_range(0, 63) * 4);
        default: addr = 32'($urandom_range(0, 63) * 4);
      endcase
      txn(sel, we, addr, 4'($urandom_range(0, 15)), $urandom,
          int'($urandom_range(0, 3)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the CPU data port: accepts load/store requests over a valid/ready handshake.
- Services each request after a programmable number of wait states and returns a response over a second valid/ready handshake.
- Replaces the zero-latency data RAM so the multi-cycle CPU variant can be exercised against realistic memory latency.
- Holds 2^ADDR_W 32-bit words with byte-lane writes.

Parameters:
- ADDR_W, 6, word-address width; storage depth is 2^ADDR_W words.
- WAIT_CYCLES, 2, wait states between acceptance and response; legal range 0..15.

Ports:
- clkin  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_be  input  4  byte enables for a store; bit i controls wdata[8i+7:8i]. Ignored for loads.
- req_wdata  input  32  store data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  32  load data; 0 for stores and for errors.
- rsp_err  output  1  request was misaligned or out of range.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, wait counter=0.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Storage contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid=1, latch we/addr/be/wdata; the request is accepted.
  - If WAIT_CYCLES>0: go to WAIT and load counter=WAIT_CYCLES-1.
  - If WAIT_CYCLES==0: perform the access and go to RESP.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - When the counter reaches 0 (that cycle), perform the access and go to RESP.
  - Acceptance-to-rsp_valid latency is WAIT_CYCLES+1 cycles.
- Access (single cycle, on the transition into RESP):
  - err = (addr[1:0]!=0) OR (addr[31:ADDR_W+2]!=0).
  - err=1: no storage update; rsp_rdata=0; rsp_err=1.
  - Store without error: write only the enabled byte lanes of word addr[ADDR_W+1:2]; rsp_rdata=0. A store with be=0 completes normally and changes nothing.
  - Load without error: rsp_rdata = word addr[ADDR_W+1:2], sampled before any update.
- RESP:
  - rsp_valid=1.
  - rsp_rdata and rsp_err held stable until rsp_ready=1.
  - On rsp_ready=1, go to IDLE and clear rsp_valid, rsp_rdata and rsp_err in the same edge.
  - req_ready=0 throughout.
  - Minimum transaction spacing is WAIT_CYCLES+2 cycles; no pipelining, one outstanding request.
- Backpressure:
  - rsp_ready held low keeps RESP indefinitely with stable outputs.
  - New requests are not accepted in this time.
- req_valid while req_ready=0: ignored. The requester must keep it asserted; request fields are not sampled.
- Reset mid-operation:
  - Return to IDLE immediately.
  - A request in WAIT is discarded without a storage update.
  - A request in RESP has already committed its write; the response is lost.
- Counter is 4 bits wide; WAIT_CYCLES>15 is illegal and enforced by an elaboration-time check.

Decomposition:
- Shared package/header holds:
  - FSM state encodings (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
  - Default ADDR_W and WAIT_CYCLES constants.
  - The error-check function for alignment and range.
- One natural sub-module: dmem_bank.
  - 2^ADDR_W x 32 storage.
  - Synchronous byte-enable write and combinational read.
  - No reset.
  - Instantiated once by dmem_responder.

Test Plan:
- Reset then idle:
  - Stimulus: reset low 3 cycles, release.
  - Response: req_ready=1, rsp_valid=0, rsp_rdata=0 throughout with no requests.
- Store then load:
  - Stimulus: store addr=0x10, be=4'hF, wdata=0xDEADBEEF; then load addr=0x10.
  - Response: each rsp_valid rises exactly 3 cycles after acceptance (WAIT_CYCLES=2); load rsp_rdata=0xDEADBEEF, rsp_err=0.
- Byte lanes:
  - Stimulus: after the previous test, store addr=0x10, be=4'b0101, wdata=0x11223344; load 0x10.
  - Response: rsp_rdata=0xDE22BE44.
- Errors:
  - Stimulus: load addr=0x12; then store addr=0x100 (ADDR_W=6).
  - Response: both give rsp_err=1, rsp_rdata=0; a subsequent load of word 0 is unchanged.
- Backpressure:
  - Stimulus: hold rsp_ready=0 for 5 cycles during a load of 0x10; keep req_valid asserted for a second request.
  - Response: rsp_valid and rsp_rdata stable, req_ready=0; the second request is accepted only on the cycle after rsp_ready=1.
- Reset mid-WAIT:
  - Stimulus: store 0x20 = 0xCAFEF00D; assert reset one cycle after acceptance; release; load 0x20.
  - Response: the load returns the prior contents of 0x20, not 0xCAFEF00D. Repeat with WAIT_CYCLES=0 and check that latency is 1 cycle.
